// File: rtl/data_mem_arbiter_if.sv
// rtl/data_mem_arbiter_if.sv - CPU, DMA and data_mem bus signals shared through the data memory arbiter
interface data_mem_arbiter_if #(
    parameter int DATA_WIDTH = 32,
    parameter int CTRL_WIDTH = 3
);
    logic                  cpu_req;
    logic                  cpu_we;
    logic [DATA_WIDTH-1:0] cpu_addr;
    logic [DATA_WIDTH-1:0] cpu_wdata;
    logic [CTRL_WIDTH-1:0] cpu_ctrl;
    logic [DATA_WIDTH-1:0] cpu_rdata;
    logic                  cpu_stall;

    logic                  dma_req;
    logic                  dma_we;
    logic [DATA_WIDTH-1:0] dma_addr;
    logic [DATA_WIDTH-1:0] dma_wdata;
    logic [CTRL_WIDTH-1:0] dma_ctrl;
    logic [DATA_WIDTH-1:0] dma_rdata;
    logic                  dma_ready;

    logic [DATA_WIDTH-1:0] mem_a;
    logic [DATA_WIDTH-1:0] mem_wd;
    logic                  mem_we;
    logic [CTRL_WIDTH-1:0] mem_ctrl;
    logic [DATA_WIDTH-1:0] mem_rd;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_ctrl,
        output cpu_rdata, cpu_stall,
        input  dma_req, dma_we, dma_addr, dma_wdata, dma_ctrl,
        output dma_rdata, dma_ready,
        output mem_a, mem_wd, mem_we, mem_ctrl,
        input  mem_rd
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_ctrl,
        input  cpu_rdata, cpu_stall,
        output dma_req, dma_we, dma_addr, dma_wdata, dma_ctrl,
        input  dma_rdata, dma_ready,
        input  mem_a, mem_wd, mem_we, mem_ctrl,
        output mem_rd
    );
endinterface

// File: rtl/data_mem_arbiter.sv
// rtl/data_mem_arbiter.sv - CPU/DMA single-port data memory arbiter; ARB_PERF_COUNTERS_EN adds perf counters
module data_mem_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int CTRL_WIDTH = 3,
    parameter int MAX_WAIT   = 8,
    parameter int BURST_LEN  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    data_mem_arbiter_if.slave     bus,
    output logic [31:0]           perf_cpu_stalls,
    output logic [31:0]           perf_dma_xfers
);
    localparam int WW = $clog2(MAX_WAIT + 1);
    localparam int BW = $clog2(BURST_LEN + 1);
    localparam logic [WW-1:0] WAIT_LAST  = WW'(MAX_WAIT - 1);
    localparam logic [BW-1:0] BURST_LAST = BW'(BURST_LEN - 1);

    typedef enum logic {CPU_OWN = 1'b0, DMA_OWN = 1'b1} state_t;

    state_t        state, state_n;
    logic [WW-1:0] wait_cnt, wait_n;
    logic [BW-1:0] burst_cnt, burst_n;
    logic          dma_sel;
    logic          stall_c, ready_c, we_c;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= CPU_OWN;
            wait_cnt  <= '0;
            burst_cnt <= '0;
        end else begin
            state     <= state_n;
            wait_cnt  <= wait_n;
            burst_cnt <= burst_n;
        end
    end

    always_comb begin
        state_n = state;
        wait_n  = wait_cnt;
        burst_n = burst_cnt;
        stall_c = 1'b0;
        ready_c = 1'b0;
        we_c    = 1'b0;
        dma_sel = 1'b0;
        case (state)
            CPU_OWN: begin
                we_c = bus.cpu_req & bus.cpu_we;
                if (bus.dma_req && bus.cpu_req)
                    wait_n = wait_cnt + 1'b1;
                if (bus.dma_req && (!bus.cpu_req || wait_cnt == WAIT_LAST)) begin
                    state_n = DMA_OWN;
                    wait_n  = '0;
                    burst_n = '0;
                end
            end
            DMA_OWN: begin
                // An idle DMA slot hands the bus straight back, so the CPU fields stay visible
                dma_sel = bus.dma_req;
                we_c    = bus.dma_req & bus.dma_we;
                ready_c = bus.dma_req;
                stall_c = bus.cpu_req;
                if (bus.dma_req)
                    burst_n = burst_cnt + 1'b1;
                if (!(!bus.cpu_req && bus.dma_req && burst_cnt < BURST_LAST))
                    state_n = CPU_OWN;
            end
            default: state_n = CPU_OWN;
        endcase
    end

    // Pending DMA work is dropped on reset: no write, no completion pulse
    assign bus.mem_we    = we_c & ~rst;
    assign bus.dma_ready = ready_c & ~rst;
    assign bus.cpu_stall = stall_c & ~rst;

    assign bus.mem_a     = dma_sel ? bus.dma_addr  : bus.cpu_addr;
    assign bus.mem_wd    = dma_sel ? bus.dma_wdata : bus.cpu_wdata;
    assign bus.mem_ctrl  = dma_sel ? bus.dma_ctrl  : bus.cpu_ctrl;

    assign bus.cpu_rdata = (state == CPU_OWN) ? bus.mem_rd : '0;
    assign bus.dma_rdata = bus.dma_ready ? bus.mem_rd : '0;

`ifdef ARB_PERF_COUNTERS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_cpu_stalls <= '0;
            perf_dma_xfers  <= '0;
        end else begin
            if (bus.cpu_stall)
                perf_cpu_stalls <= perf_cpu_stalls + 32'd1;
            if (bus.dma_ready)
                perf_dma_xfers  <= perf_dma_xfers + 32'd1;
        end
    end
`else
    assign perf_cpu_stalls = '0;
    assign perf_dma_xfers  = '0;
`endif
endmodule

// File: tb/tb_data_mem_arbiter.sv
// tb/tb_data_mem_arbiter.sv - directed self-checking bench for data_mem_arbiter
module tb_data_mem_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] perf_cpu_stalls;
    logic [31:0] perf_dma_xfers;
    logic [31:0] mem [0:255];
    int          vectors = 0;
    int          errors  = 0;

    always #5 clk = ~clk;

    data_mem_arbiter_if #(.DATA_WIDTH(32), .CTRL_WIDTH(3)) bus ();

    data_mem_arbiter #(
        .DATA_WIDTH(32), .CTRL_WIDTH(3), .MAX_WAIT(8), .BURST_LEN(4)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .bus             (bus.slave),
        .perf_cpu_stalls (perf_cpu_stalls),
        .perf_dma_xfers  (perf_dma_xfers)
    );

    assign bus.mem_rd = mem[bus.mem_a[9:2]];
    always @(posedge clk)
        if (bus.mem_we) mem[bus.mem_a[9:2]] <= bus.mem_wd;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    initial begin
        logic [7:0]  burst_pat;
        int          served;
        logic [31:0] exp_perf;

        for (int i = 0; i < 256; i++) mem[i] = '0;
        bus.cpu_req = 0; bus.cpu_we = 0; bus.cpu_addr = 0; bus.cpu_wdata = 0; bus.cpu_ctrl = 3'd2;
        bus.dma_req = 0; bus.dma_we = 0; bus.dma_addr = 0; bus.dma_wdata = 0; bus.dma_ctrl = 3'd2;

        // reset: write request must not reach memory
        rst = 1;
        tick();
        bus.cpu_req = 1; bus.cpu_we = 1; bus.cpu_addr = 32'h10; bus.cpu_wdata = 32'h5555_5555;
        settle();
        chk("rst_mem_we", {31'd0, bus.mem_we}, 32'd0);
        chk("rst_stall", {31'd0, bus.cpu_stall}, 32'd0);
        chk("rst_ready", {31'd0, bus.dma_ready}, 32'd0);
        tick();
        rst = 0;

        // 1: CPU store then load
        bus.cpu_req = 1; bus.cpu_we = 1; bus.cpu_addr = 32'h10; bus.cpu_wdata = 32'hDEADBEEF;
        settle();
        chk("t1_store_we", {31'd0, bus.mem_we}, 32'd1);
        chk("t1_store_stall", {31'd0, bus.cpu_stall}, 32'd0);
        tick();
        bus.cpu_we = 0;
        settle();
        chk("t1_load_data", bus.cpu_rdata, 32'hDEADBEEF);
        chk("t1_load_stall", {31'd0, bus.cpu_stall}, 32'd0);
        chk("t1_load_we", {31'd0, bus.mem_we}, 32'd0);
        tick();

        // 2: single DMA write, CPU idle
        bus.cpu_req = 0; bus.cpu_addr = 32'h100;
        bus.dma_req = 1; bus.dma_we = 1; bus.dma_addr = 32'h20; bus.dma_wdata = 32'h12345678;
        settle();
        chk("t2_n_ready", {31'd0, bus.dma_ready}, 32'd0);
        chk("t2_n_we", {31'd0, bus.mem_we}, 32'd0);
        tick();
        settle();
        chk("t2_n1_ready", {31'd0, bus.dma_ready}, 32'd1);
        chk("t2_n1_we", {31'd0, bus.mem_we}, 32'd1);
        chk("t2_n1_addr", bus.mem_a, 32'h20);
        tick();
        bus.dma_req = 0; bus.dma_we = 0;
        settle();
        chk("t2_idle_we", {31'd0, bus.mem_we}, 32'd0);
        chk("t2_idle_ready", {31'd0, bus.dma_ready}, 32'd0);
        chk("t2_idle_addr", bus.mem_a, 32'h100);
        tick();
        bus.cpu_req = 1; bus.cpu_addr = 32'h20;
        settle();
        chk("t2_readback", bus.cpu_rdata, 32'h12345678);
        chk("t2_readback_stall", {31'd0, bus.cpu_stall}, 32'd0);
        tick();

        // 3: contention, DMA forced in on the 9th cycle
        bus.cpu_req = 1; bus.cpu_we = 0; bus.cpu_addr = 32'h10;
        bus.dma_req = 1; bus.dma_we = 0; bus.dma_addr = 32'h20;
        for (int i = 0; i < 9; i++) begin
            settle();
            chk($sformatf("t3_stall_c%0d", i), {31'd0, bus.cpu_stall}, {31'd0, i == 8});
            chk($sformatf("t3_ready_c%0d", i), {31'd0, bus.dma_ready}, {31'd0, i == 8});
            if (i == 8) chk("t3_dma_rdata", bus.dma_rdata, 32'h12345678);
            else        chk($sformatf("t3_cpu_rdata_c%0d", i), bus.cpu_rdata, 32'hDEADBEEF);
            tick();
        end
        bus.dma_req = 0;
        settle();
        chk("t3_back_stall", {31'd0, bus.cpu_stall}, 32'd0);
        chk("t3_back_rdata", bus.cpu_rdata, 32'hDEADBEEF);
        tick();

        // 4: six DMA writes, BURST_LEN 4 forces one CPU_OWN gap
        bus.cpu_req = 0;
        burst_pat = 8'b1101_1110;
        served = 0;
        for (int c = 0; c < 8; c++) begin
            bus.dma_req   = (served < 6);
            bus.dma_we    = 1;
            bus.dma_addr  = 32'h40 + 32'(served) * 4;
            bus.dma_wdata = 32'(served) + 1;
            settle();
            chk($sformatf("t4_ready_c%0d", c), {31'd0, bus.dma_ready}, {31'd0, burst_pat[c]});
            if (burst_pat[c]) served++;
            tick();
        end
        bus.dma_req = 0; bus.dma_we = 0;
        tick();
        bus.cpu_req = 1; bus.cpu_addr = 32'h54;
        settle();
        chk("t4_last_word", bus.cpu_rdata, 32'd6);
        bus.cpu_addr = 32'h4C;
        settle();
        chk("t4_gap_word", bus.cpu_rdata, 32'd4);
        tick();

        // 5: reset mid-burst
        bus.cpu_req = 0;
        bus.dma_req = 1; bus.dma_we = 1; bus.dma_addr = 32'h80; bus.dma_wdata = 32'hAA;
        tick();
        settle();
        chk("t5_first_ready", {31'd0, bus.dma_ready}, 32'd1);
        tick();
        bus.dma_addr = 32'h84; bus.dma_wdata = 32'hBB;
        rst = 1;
        settle();
        chk("t5_rst_we", {31'd0, bus.mem_we}, 32'd0);
        chk("t5_rst_ready", {31'd0, bus.dma_ready}, 32'd0);
        chk("t5_rst_stall", {31'd0, bus.cpu_stall}, 32'd0);
        tick();
        rst = 0;
        bus.dma_req = 0; bus.dma_we = 0;
        bus.cpu_req = 1; bus.cpu_addr = 32'h84;
        settle();
        chk("t5_post_stall", {31'd0, bus.cpu_stall}, 32'd0);
        chk("t5_post_ready", {31'd0, bus.dma_ready}, 32'd0);
        chk("t5_no_write", bus.cpu_rdata, 32'd0);
        bus.cpu_addr = 32'h80;
        settle();
        chk("t5_pre_rst_write", bus.cpu_rdata, 32'hAA);
        tick();

        // 6: perf counters over 18 contended cycles
        rst = 1;
        tick();
        rst = 0;
        bus.cpu_req = 1; bus.cpu_we = 0; bus.cpu_addr = 32'h10;
        bus.dma_req = 1; bus.dma_we = 0; bus.dma_addr = 32'h20;
        for (int i = 0; i < 18; i++) tick();
        bus.cpu_req = 0; bus.dma_req = 0;
`ifdef ARB_PERF_COUNTERS_EN
        exp_perf = 32'd2;
`else
        exp_perf = 32'd0;
`endif
        settle();
        chk("t6_perf_stalls", perf_cpu_stalls, exp_perf);
        chk("t6_perf_xfers", perf_dma_xfers, exp_perf);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule

// File: doc/data_mem_arbiter.md
Name: data_mem_arbiter

Overview:
- Shares the single-port data memory between the pipeline MEM stage (CPU port) and a secondary bus master (DMA/loader port).
- The CPU gets zero-latency pass-through by default. DMA accesses are inserted by a 2-state FSM with a starvation guard and a burst limit.
- Sits between the MEM stage / DMA engine and data_mem. Drives the pipeline stall when the CPU loses arbitration.

Parameters:
- DATA_WIDTH, 32, data and address width.
- CTRL_WIDTH, 3, width of the AddressingControl field (byte/half/word, signed/unsigned).
- MAX_WAIT, 8, max consecutive cycles DMA may be denied before a forced grant (≥1).
- BURST_LEN, 4, max consecutive DMA accesses per grant (≥1).

Ports:
- clk  input  1  system clock, all state on rising edge
- rst  input  1  synchronous active-high reset
- cpu_req  input  1  MEM stage access request (load or store)
- cpu_we  input  1  CPU store enable
- cpu_addr  input  DATA_WIDTH  CPU address (ALU result)
- cpu_wdata  input  DATA_WIDTH  CPU store data
- cpu_ctrl  input  CTRL_WIDTH  CPU addressing control
- cpu_rdata  output  DATA_WIDTH  load data to CPU
- cpu_stall  output  1  high when cpu_req is not served this cycle
- dma_req  input  1  DMA request; held with fields stable until dma_ready
- dma_we  input  1  DMA write enable
- dma_addr  input  DATA_WIDTH  DMA address
- dma_wdata  input  DATA_WIDTH  DMA write data
- dma_ctrl  input  CTRL_WIDTH  DMA addressing control
- dma_rdata  output  DATA_WIDTH  read data to DMA
- dma_ready  output  1  one-cycle pulse; DMA access completed this cycle
- mem_a  output  DATA_WIDTH  to data_mem A
- mem_wd  output  DATA_WIDTH  to data_mem WD
- mem_we  output  1  to data_mem WE
- mem_ctrl  output  CTRL_WIDTH  to data_mem AddressingControl
- mem_rd  input  DATA_WIDTH  from data_mem RD (combinational read)
- perf_cpu_stalls  output  32  CPU stall cycle count (optional feature)
- perf_dma_xfers  output  32  completed DMA access count (optional feature)

Behaviour:
- State register, two states: CPU_OWN and DMA_OWN. Reset state is CPU_OWN; wait_cnt and burst_cnt reset to 0.
- Single clock domain (clk). Synchronous active-high reset (rst) returns the FSM and counters to reset values on the next edge, including mid-burst. Any DMA access pending when rst is asserted is dropped without dma_ready.

CPU_OWN:
- mem_* driven from cpu_* fields; mem_we = cpu_req & cpu_we.
- cpu_stall = 0 and dma_ready = 0. Write commits at the edge (data_mem timing).
- Counter wait_cnt increments when dma_req & cpu_req, and holds otherwise.
- Go to DMA_OWN when dma_req & (!cpu_req | wait_cnt == MAX_WAIT-1). On the transition, clear wait_cnt and burst_cnt.
- DMA is never served in CPU_OWN. Minimum DMA latency is therefore 1 cycle (req at cycle N, dma_ready at N+1).

DMA_OWN:
- mem_* driven from dma_* fields; mem_we = dma_req & dma_we.
- dma_ready = dma_req. cpu_stall = cpu_req.
- burst_cnt increments on each served access.
- Stay in DMA_OWN when !cpu_req & dma_req & burst_cnt < BURST_LEN-1. Otherwise go to CPU_OWN.
- dma_req low in DMA_OWN: no memory write, no dma_ready, return to CPU_OWN.

Read data and idle values:
- cpu_rdata = mem_rd in CPU_OWN, else 0. dma_rdata = mem_rd when dma_ready, else 0.
- With no requests, outputs are mem_we = 0 and mem_a/mem_wd/mem_ctrl following the CPU fields.
- Reset values: cpu_stall = 0, dma_ready = 0, mem_we = 0 while rst is high (state is CPU_OWN, and mem_we is forced low during reset).

Guarantees and boundaries:
- At most one port writes per cycle.
- CPU starvation is bounded to BURST_LEN cycles. DMA starvation is bounded to MAX_WAIT cycles.
- MAX_WAIT = 1: DMA wins on the first contended cycle.

Optional Feature:
- Macro ARB_PERF_COUNTERS_EN.
- When defined: perf_cpu_stalls increments each cycle cpu_stall = 1, and perf_dma_xfers increments each dma_ready pulse. Both are 32-bit, wrap at 2^32-1 to 0, and clear on rst.
- When not defined: both ports are present and tied to 0, and no counter flops are inferred.

Test Plan:
1. CPU only: cpu_req=1, cpu_we=1, addr 0x10, wdata 0xDEADBEEF, then load 0x10 -> cpu_stall never 1; load returns 0xDEADBEEF the same cycle.
2. DMA only, single write 0x20 <= 0x12345678, cpu_req=0 -> dma_ready at cycle N+1; mem_we high only that cycle; a CPU read of 0x20 afterwards returns 0x12345678.
3. Continuous cpu_req and dma_req with MAX_WAIT=8 -> DMA served in the 9th cycle; cpu_stall high exactly that one cycle; then back to CPU_OWN.
4. DMA burst of 6 requests, cpu_req=0, BURST_LEN=4 -> 4 back-to-back dma_ready pulses, one CPU_OWN gap cycle, then the remaining 2.
5. rst asserted while in DMA_OWN mid-burst -> next cycle state is CPU_OWN, dma_ready=0, cpu_stall=0, and no write occurs during the reset cycle.
6. With ARB_PERF_COUNTERS_EN defined, run scenario 3 for 18 cycles -> perf_cpu_stalls=2 and perf_dma_xfers=2. Without the macro, both read 0.
